// File: rtl/mvm_sequencer.sv
// Binary-vector x 6x6 coefficient matrix product, emitted one column per handshake.
// Each column accumulates one row per cycle, then holds the result until it is accepted.
module mvm_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [5:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       start,
  input  logic [5:0] vec,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_col,
  output logic [7:0] out_data,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic [7:0]  acc_q, acc_d;
  logic [5:0]  vec_q, vec_d;
  logic        busy_q, busy_d;
  logic        out_valid_q, out_valid_d;
  logic [2:0]  out_col_q, out_col_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  m_q [36];
  logic [7:0]  m_d [36];
  logic [5:0]  rd_idx;

  // Flat coefficient index row*6+col, matching the cfg_addr encoding.
  assign rd_idx = 6'(row_q) * 6'd6 + 6'(col_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    vec_d       = vec_q;
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    err_d       = err_q;
    m_d         = m_q;

    if (cfg_we) begin
      if (state_q == IDLE && cfg_addr <= 6'd35) m_d[cfg_addr] = cfg_data;
      else                                      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          vec_d   = vec;
          col_d   = 3'd0;
          row_d   = 3'd0;
          acc_d   = 8'd0;
        end
      end
      ACC: begin
        acc_d = acc_q + (vec_q[row_q] ? m_q[rd_idx] : 8'd0);
        row_d = row_q + 3'd1;
        if (row_q == 3'd5) begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_col_d   = col_q;
          out_data_d  = acc_d;
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (col_q == 3'd5) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ACC;
            col_d   = col_q + 3'd1;
            row_d   = 3'd0;
            acc_d   = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      acc_q       <= 8'd0;
      vec_q       <= 6'd0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_col_q   <= 3'd0;
      out_data_q  <= 8'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      // NOTE: the coefficient array is reset deliberately because reset must restore the default matrix.
      for (int i = 0; i < 36; i++) m_q[i] <= 8'(i + 1);
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      m_q         <= m_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mvm_sequencer.sv
// Directed bench for mvm_sequencer: column values, latency, back-pressure,
// rejected writes, start/write collision and mid-product reset.
module tb_mvm_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [5:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       start;
  logic [5:0] vec;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_col;
  logic [7:0] out_data;
  logic       done;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  mvm_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .vec       (vec),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_data  (out_data),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 6'd0; cfg_data = 8'd0;
    start = 1'b0; vec = 6'd0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // Runs one product; optionally stalls one column and/or disturbs the DUT mid-ACC.
  task automatic run_product(input string name, input logic [5:0] v,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5,
                             input int stall_col, input int stall_cycles, input bit disturb);
    logic [7:0] exp_v [6];
    int n = 0;
    int col = 0;
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3; exp_v[4] = e4; exp_v[5] = e5;
    start = 1'b1; vec = v; out_ready = 1'b1;
    step();
    start = 1'b0; cfg_we = 1'b0;
    while (col < 6 && n < 300) begin
      if (disturb && n == 2) begin
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 8'h00; vec = 6'd0; start = 1'b1;
      end else if (disturb && n == 3) begin
        cfg_we = 1'b0; start = 1'b0;
      end
      step(); n++;
      if (out_valid) begin
        if (col == 0) begin
          if (n !== 6) begin
            $display("FAIL %s first_valid_latency: got %0d want 6", name, n); miscompares++;
          end
          vectors++;
        end
        if (out_col !== 3'(col)) begin
          $display("FAIL %s out_col: got %0d want %0d", name, out_col, col); miscompares++;
        end
        vectors++;
        if (out_data !== exp_v[col]) begin
          $display("FAIL %s out_data[%0d]: got %0d want %0d", name, col, out_data, exp_v[col]);
          miscompares++;
        end
        vectors++;
        if (col == stall_col) begin
          out_ready = 1'b0;
          for (int k = 0; k < stall_cycles; k++) begin
            step(); n++;
            if (out_valid !== 1'b1 || out_col !== 3'(col) || out_data !== exp_v[col]) begin
              $display("FAIL %s stall_stable: valid=%b col=%0d data=%0d want 1/%0d/%0d",
                       name, out_valid, out_col, out_data, col, exp_v[col]);
              miscompares++;
            end
            vectors++;
          end
          out_ready = 1'b1;
        end
        step(); n++;
        if (col == 5) begin
          if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL %s done_after_last: done=%b busy=%b want 1/0", name, done, busy);
            miscompares++;
          end
          vectors++;
          if (n !== 42 + stall_cycles) begin
            $display("FAIL %s total_cycles: got %0d want %0d", name, n, 42 + stall_cycles);
            miscompares++;
          end
          vectors++;
        end else begin
          if (out_valid !== 1'b0 || done !== 1'b0) begin
            $display("FAIL %s after_handshake: valid=%b done=%b want 0/0", name, out_valid, done);
            miscompares++;
          end
          vectors++;
        end
        col++;
      end
    end
    if (col < 6) begin
      $display("FAIL %s timeout: columns seen %0d want 6", name, col); miscompares++;
      vectors++;
    end
    vec = 6'd0;
    step();
    if (done !== 1'b0) begin
      $display("FAIL %s done_width: got %b want 0", name, done); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 6'd0; cfg_data = 8'd0;
    start = 1'b0; vec = 6'd0; out_ready = 1'b1;
    #3;
    if ({busy, out_valid, done, err} !== 4'b0000 || out_col !== 3'd0 || out_data !== 8'd0) begin
      $display("FAIL reset_state: busy/valid/done/err=%b%b%b%b col=%0d data=%0d want 0000/0/0",
               busy, out_valid, done, err, out_col, out_data);
      miscompares++;
    end
    vectors++;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_unit_vector();
    run_product("unit", 6'b000001, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, -1, 0, 1'b0);
  endtask

  task automatic test_all_rows();
    do_reset();
    run_product("all_rows", 6'b111111, 8'd96, 8'd102, 8'd108, 8'd114, 8'd120, 8'd126, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_reset();
    run_product("stall", 6'b000001, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 2, 10, 1'b0);
  endtask

  task automatic test_err_busy_write();
    do_reset();
    run_product("busy_write", 6'b111111, 8'd96, 8'd102, 8'd108, 8'd114, 8'd120, 8'd126,
                -1, 0, 1'b1);
    if (err !== 1'b1) begin
      $display("FAIL busy_write_err: got %b want 1", err); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_err_bad_addr();
    do_reset();
    if (err !== 1'b0) begin
      $display("FAIL err_cleared_by_reset: got %b want 0", err); miscompares++;
    end
    vectors++;
    cfg_we = 1'b1; cfg_addr = 6'd40; cfg_data = 8'h00;
    step();
    cfg_we = 1'b0;
    step(); step();
    if (err !== 1'b1) begin
      $display("FAIL bad_addr_err: got %b want 1", err); miscompares++;
    end
    vectors++;
    run_product("bad_addr", 6'b111111, 8'd96, 8'd102, 8'd108, 8'd114, 8'd120, 8'd126,
                -1, 0, 1'b0);
    if (err !== 1'b1) begin
      $display("FAIL err_sticky: got %b want 1", err); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int a = 0; a < 36; a++) begin
      cfg_we = 1'b1; cfg_addr = 6'(a); cfg_data = 8'hFF;
      step();
    end
    cfg_we = 1'b0;
    run_product("wrap", 6'b111111, 8'hFA, 8'hFA, 8'hFA, 8'hFA, 8'hFA, 8'hFA, -1, 0, 1'b0);
  endtask

  task automatic test_start_with_write();
    do_reset();
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 8'h10;
    run_product("start_write", 6'b000001, 8'h10, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1; vec = 6'b000001;
    step();
    start = 1'b0;
    for (int k = 0; k < 23; k++) step();
    #2 rst = 1'b1;
    #1;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      $display("FAIL mid_reset_abort: busy=%b valid=%b done=%b want 0/0/0", busy, out_valid, done);
      miscompares++;
    end
    vectors++;
    step();
    rst = 1'b0;
    step(); step();
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL mid_reset_no_done: done=%b busy=%b want 0/0", done, busy); miscompares++;
    end
    vectors++;
    run_product("after_abort", 6'b000001, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_unit_vector();
    test_all_rows();
    test_backpressure();
    test_err_busy_write();
    test_err_bad_addr();
    test_wrap();
    test_start_with_write();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
